// File: rtl/clkscale_pkg.sv
// clkscale_pkg: state encoding and default widths shared by the clock-scale scheduler.
package clkscale_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
    localparam int SCALEW_D = 32;
    localparam int TICKW_D  = 16;
endpackage

// File: rtl/clkscale_sched_if.sv
// clkscale_sched_if: requester bus of the clock-scale scheduler (master = requesters, slave = scheduler).
interface clkscale_sched_if #(
    parameter int NREQ   = 4,
    parameter int SCALEW = clkscale_pkg::SCALEW_D,
    parameter int TICKW  = clkscale_pkg::TICKW_D
);
    logic [NREQ-1:0]        req;
    logic [NREQ*SCALEW-1:0] scale;
    logic [NREQ*TICKW-1:0]  ticks;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic                   tick;
    logic                   clk_out;
    logic                   busy;
    modport master (output req, scale, ticks, input gnt, done, tick, clk_out, busy);
    modport slave  (input req, scale, ticks, output gnt, done, tick, clk_out, busy);
endinterface

// File: rtl/clkscale_tick_gen.sv
// clkscale_tick_gen: programmable divider; latches the effective scale on clr, ticks once per period while en.
module clkscale_tick_gen
    import clkscale_pkg::*;
#(
    parameter int SCALEW = SCALEW_D
) (
    input  logic              CCLK,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [SCALEW-1:0] scale,
    output logic              tick,
    output logic              clk_out
);
    logic [SCALEW-1:0] eff_q, cnt_q;
    logic              clk_out_q;
    assign tick    = en && (cnt_q == eff_q - SCALEW'(1));
    assign clk_out = clk_out_q;
    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            eff_q     <= '0;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else if (clr) begin
            eff_q     <= (scale == '0) ? SCALEW'(1) : scale;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else if (en) begin
            cnt_q     <= tick ? '0 : cnt_q + SCALEW'(1);
            clk_out_q <= clk_out_q ^ tick;
        end
    end
endmodule

// File: rtl/clkscale_sched.sv
// clkscale_sched: round-robin scheduler sharing one tick divider among NREQ requesters.
// Define CLKSCHED_ABORT_EN to end a grant early when its requester drops req during RUN.
module clkscale_sched
    import clkscale_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SCALEW = SCALEW_D,
    parameter int TICKW  = TICKW_D
) (
    input logic             CCLK,
    input logic             rst_n,
    clkscale_sched_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    typedef logic [PW:0]     idx_t;
    typedef logic [NREQ-1:0] vec_t;
    state_t           state_q, state_d;
    logic [PW-1:0]    win_q, win_d, rr_q;
    logic [TICKW-1:0] left_q, budget;
    vec_t             gnt_q;
    idx_t             idx;
    logic             found, load, run_en, tick, clk_out, last_tick;
    // First requester at or after the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        win_d = win_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = idx_t'(rr_q) + idx_t'(i);
            idx = (idx >= idx_t'(NREQ)) ? idx - idx_t'(NREQ) : idx;
            if (!found && bus.req[idx[PW-1:0]]) begin
                win_d = idx[PW-1:0];
                found = 1'b1;
            end
        end
    end
    assign load      = (state_q == S_IDLE) && found;
`ifdef CLKSCHED_ABORT_EN
    assign run_en    = (state_q == S_RUN) && bus.req[win_q];
`else
    assign run_en    = state_q == S_RUN;
`endif
    assign last_tick = tick && (left_q == TICKW'(1));
    assign budget    = bus.ticks[win_d*TICKW +: TICKW];
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = found ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   state_d = (last_tick || !run_en) ? S_DONE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    // Slot values are captured on entry to LOAD so later changes cannot disturb the grant.
    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            rr_q    <= '0;
            left_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                win_q  <= win_d;
                left_q <= (budget == '0) ? TICKW'(1) : budget;
                gnt_q  <= vec_t'(1) << win_d;
            end
            if (tick) left_q <= left_q - TICKW'(1);
            if (state_d == S_DONE) gnt_q <= '0;
            if (state_q == S_DONE) rr_q <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        end
    end
    clkscale_tick_gen #(.SCALEW(SCALEW)) u_tick (
        .CCLK    (CCLK),
        .rst_n   (rst_n),
        .clr     (load),
        .en      (run_en),
        .scale   (bus.scale[win_d*SCALEW +: SCALEW]),
        .tick    (tick),
        .clk_out (clk_out)
    );
    assign bus.gnt     = gnt_q;
    assign bus.done    = (state_q == S_DONE) ? vec_t'(1) << win_q : '0;
    assign bus.tick    = tick;
    assign bus.clk_out = clk_out;
    assign bus.busy    = state_q != S_IDLE;
endmodule
